// File: rtl/dsp_mac_sequencer.sv
// Control stage that streams (A, B) operand beats into a DSP48A1 slice to accumulate a dot product,
// then waits out the slice pipeline and presents the captured P over a valid/ready output.
`timescale 1ns/1ps
module dsp_mac_sequencer #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned ACC_W    = 48,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned MAX_TAPS = 1024,
    localparam int unsigned CNT_W   = $clog2(MAX_TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_neg,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic [DATA_W-1:0] dsp_a,
    output logic [DATA_W-1:0] dsp_b,
    output logic [7:0]        dsp_opmode,
    output logic              dsp_ce,
    input  logic [ACC_W-1:0]  dsp_p
);

    localparam int unsigned DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StHold
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               first_beat;

    assign accept     = in_valid & in_ready;
    assign first_beat = (state == StIdle);

    // Operands go straight to the slice; idle cycles select X=0, Z=P so P holds its value.
    always_comb begin
        dsp_a      = '0;
        dsp_b      = '0;
        dsp_opmode = 8'h08;
        if (accept) begin
            dsp_a      = in_a;
            dsp_b      = in_b;
            dsp_opmode = {in_neg, 3'b000, ~first_beat, 3'b001};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            in_ready  <= 1'b0;
            dsp_ce    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            dsp_ce <= 1'b1;
            unique case (state)
                StIdle, StAccum: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (state == StIdle) begin
                            out_count <= CNT_W'(1);
                            out_sat   <= 1'b0;
                        end else if (out_count == CNT_W'(MAX_TAPS)) begin
                            out_sat <= 1'b1;
                        end else begin
                            out_count <= out_count + 1'b1;
                        end
                        if (in_last) begin
                            state     <= StDrain;
                            in_ready  <= 1'b0;
                            drain_cnt <= DRAIN_W'(LATENCY - 1);
                        end else begin
                            state <= StAccum;
                        end
                    end
                end
                StDrain: begin
                    if (drain_cnt == '0) begin
                        out_data  <= dsp_p;
                        out_valid <= 1'b1;
                        state     <= StHold;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 slice closes the loop, and expected results
// come from a plain signed-sum model of each job.
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

    localparam int DW  = 18;
    localparam int AW  = 48;
    localparam int LAT = 2;
    localparam int MT  = 4;
    localparam int CW  = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_neg, in_last;
    logic [DW-1:0] in_a, in_b;
    logic          out_valid, out_ready, out_sat;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic [DW-1:0] dsp_a, dsp_b;
    logic [7:0]    dsp_opmode;
    logic          dsp_ce;
    logic [AW-1:0] dsp_p;

    dsp_mac_sequencer #(
        .DATA_W  (DW),
        .ACC_W   (AW),
        .LATENCY (LAT),
        .MAX_TAPS(MT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_opmode(dsp_opmode),
        .dsp_ce    (dsp_ce),
        .dsp_p     (dsp_p)
    );

    always #5 clk = ~clk;

    // Slice model: OPMODE and M registered together, then P; stale P preloaded with junk.
    logic [7:0]    op_q = 8'h08;
    logic [AW-1:0] m_q  = '0;
    logic [AW-1:0] p_q  = 48'h1234_5678_9ABC;
    logic [AW-1:0] zsel, xsel;
    assign zsel  = (op_q[3:2] == 2'b10) ? p_q : '0;
    assign xsel  = (op_q[1:0] == 2'b01) ? m_q : '0;
    assign dsp_p = p_q;
    always @(posedge clk) begin
        if (dsp_ce) begin
            op_q <= dsp_opmode;
            m_q  <= AW'(dsp_a) * AW'(dsp_b);
            p_q  <= op_q[7] ? zsel - xsel : zsel + xsel;
        end
    end

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] ja[16];
    logic [DW-1:0] jb[16];
    logic          jn[16];
    int            jlen;

    function automatic logic [AW-1:0] ref_sum();
        logic [AW-1:0] s = '0;
        for (int i = 0; i < jlen; i++) begin
            if (jn[i]) s = s - AW'(ja[i]) * AW'(jb[i]);
            else       s = s + AW'(ja[i]) * AW'(jb[i]);
        end
        return s;
    endfunction

    task automatic run_job(input int gap, input int stall);
        logic [AW-1:0] exp_data;
        logic [7:0]    exp_op;
        int            w;
        int            lat;
        exp_data  = ref_sum();
        out_ready = 1'b0;
        for (int i = 0; i < jlen; i++) begin
            in_valid = 1'b1;
            in_a     = ja[i];
            in_b     = jb[i];
            in_neg   = jn[i];
            in_last  = (i == jlen - 1);
            w = 0;
            while (!in_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            chk("in_ready_beat", 64'(in_ready), 64'(1));
            @(negedge clk);
            if (i == 0) exp_op = jn[i] ? 8'h81 : 8'h01;
            else        exp_op = jn[i] ? 8'h89 : 8'h09;
            chk("opmode_beat", 64'(dsp_opmode), 64'(exp_op));
            chk("dsp_ab", 64'({dsp_a, dsp_b}), 64'({ja[i], jb[i]}));
            @(posedge clk); #1;
            if (i == 0 && gap > 0 && jlen > 1) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                repeat (gap) begin
                    @(negedge clk);
                    chk("opmode_gap", 64'(dsp_opmode), 64'(8'h08));
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT + 1));
        repeat (stall) begin
            @(negedge clk);
            chk("hold_data", 64'(out_data), 64'(exp_data));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(1));
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("out_count", 64'(out_count), 64'((jlen > MT) ? MT : jlen));
        chk("out_sat", 64'(out_sat), 64'(jlen > MT));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'(0));
        chk("ready_back", 64'(in_ready), 64'(1));
    endtask

    task automatic set_beat(input int i, input int a, input int b, input logic n);
        ja[i] = DW'(a);
        jb[i] = DW'(b);
        jn[i] = n;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_neg    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_count", 64'(out_count), 64'(0));
        chk("rst_out_sat", 64'(out_sat), 64'(0));
        chk("rst_dsp_ab", 64'({dsp_a, dsp_b}), 64'(0));
        chk("rst_opmode", 64'(dsp_opmode), 64'(8'h08));
        chk("rst_ce", 64'(dsp_ce), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        chk("post_rst_ce", 64'(dsp_ce), 64'(1));

        // 3-beat job, no gaps, then with a 2-cycle gap (in_last asserted while idle).
        jlen = 3;
        set_beat(0, 2, 3, 1'b0);
        set_beat(1, 4, 5, 1'b0);
        set_beat(2, 6, 7, 1'b0);
        run_job(0, 0);
        run_job(2, 0);

        jlen = 2;
        set_beat(0, 10, 10, 1'b0);
        set_beat(1, 2, 3, 1'b1);
        run_job(0, 0);

        jlen = 1;
        set_beat(0, 2, 3, 1'b1);
        run_job(0, 0);
        chk("neg_literal", 64'(out_data), 64'(48'hFFFF_FFFF_FFFA));

        // Stalled output, then a fresh job that must not see the old P.
        jlen = 3;
        set_beat(0, 2, 3, 1'b0);
        set_beat(1, 4, 5, 1'b0);
        set_beat(2, 6, 7, 1'b0);
        run_job(0, 5);
        jlen = 1;
        set_beat(0, 1, 1, 1'b0);
        run_job(0, 0);

        // Reset while draining discards the job.
        in_valid = 1'b1;
        in_a     = DW'(100);
        in_b     = DW'(100);
        in_neg   = 1'b0;
        in_last  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_ready", 64'(in_ready), 64'(0));
        chk("midrst_ce", 64'(dsp_ce), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_valid_after_rst", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        jlen = 1;
        set_beat(0, 3, 3, 1'b0);
        run_job(0, 0);

        // Saturation: 6 beats against a 4-tap limit.
        jlen = 6;
        for (int i = 0; i < 6; i++) set_beat(i, 1, 1, 1'b0);
        run_job(0, 0);

        for (int k = 0; k < 20; k++) begin
            jlen = int'($urandom_range(1, 6));
            for (int i = 0; i < jlen; i++) begin
                ja[i] = DW'($urandom);
                jb[i] = DW'($urandom);
                jn[i] = 1'($urandom);
            end
            run_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
